vec_wb_sequencer: RTL

VEC_WB_SEQUENCER -- requirements
Module: vec_wb_sequencer

---
 rtl/vec_wb_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vec_wb_sequencer.sv
// vec_wb_sequencer: collects result beats into a merge buffer preloaded with the old destination group, then writes it back once
module vec_wb_sequencer #(
  parameter int VLEN     = 512,
  parameter int MAX_VLEN = 4096,
  parameter int BEAT_W   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [4:0]          waddr,
  input  logic [3:0]          lmul,
  input  logic [1:0]          sew,
  input  logic [9:0]          vl,
  input  logic                mask_en,
  input  logic [VLEN-1:0]     v0_mask_data,
  input  logic [MAX_VLEN-1:0] dst_data,
  input  logic                beat_valid,
  input  logic [BEAT_W-1:0]   beat_data,
  output logic                beat_ready,
  output logic                wr_en,
  output logic [4:0]          wr_addr,
  output logic [MAX_VLEN-1:0] wdata,
  input  logic                data_written,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int AW = $clog2(MAX_VLEN);
  localparam int VW = $clog2(VLEN);
  typedef enum logic [2:0] {IDLE, LOAD, COLLECT, WRITE, WAIT} state_t;
  state_t state_q, state_d;
  logic [4:0] waddr_q, waddr_d;
  logic [1:0] sew_q, sew_d;
  logic [9:0] vl_q, vl_d;
  logic mask_q, mask_d;
  logic [6:0] n_q, n_d, cnt_q, cnt_d;
  logic [MAX_VLEN-1:0] buf_q, buf_d;
  logic done_q, done_d, err_q, err_d;
  logic [31:0] max_el, req_beats, el;
  logic [AW-1:0] base;
  logic [BEAT_W-1:0] old_beat, new_beat;
  logic bad, last;
  assign max_el    = (32'(lmul) * VLEN) >> (3 + sew);
  assign req_beats = ((32'(vl) << (3 + sew)) + BEAT_W - 1) / BEAT_W;
  assign bad       = !(lmul inside {4'd1, 4'd2, 4'd4, 4'd8}) || |(waddr & (5'(lmul) - 5'd1)) || 32'(vl) > max_el;
  assign base      = AW'(32'(cnt_q) * BEAT_W);
  assign old_beat  = buf_q[base +: BEAT_W];
  assign last      = cnt_q == n_q - 7'd1;
  // Each bit maps to an element; masked-off or tail elements keep the preloaded destination bits
  always_comb begin
    new_beat = old_beat;
    el = '0;
    for (int j = 0; j < BEAT_W; j++) begin
      el = (32'(base) + 32'(j)) >> (3 + sew_q);
      new_beat[j] = (el < 32'(vl_q) && (!mask_q || v0_mask_data[el[VW-1:0]])) ? beat_data[j] : old_beat[j];
    end
  end
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    sew_d   = sew_q;
    vl_d    = vl_q;
    mask_d  = mask_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        err_d   = bad;
        state_d = bad ? IDLE : LOAD;
        if (!bad) begin
          waddr_d = waddr;
          sew_d   = sew;
          vl_d    = vl;
          mask_d  = mask_en;
          n_d     = 7'(req_beats);
        end
      end
      LOAD: begin
        cnt_d   = '0;
        buf_d   = dst_data;
        done_d  = vl_q == '0;
        state_d = vl_q == '0 ? IDLE : COLLECT;
      end
      COLLECT: if (beat_valid) begin
        buf_d[base +: BEAT_W] = new_beat;
        cnt_d   = last ? cnt_q : cnt_q + 7'd1;
        state_d = last ? WRITE : COLLECT;
      end
      WRITE: state_d = WAIT;
      WAIT: if (data_written) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      sew_q   <= '0;
      vl_q    <= '0;
      mask_q  <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      sew_q   <= sew_d;
      vl_q    <= vl_d;
      mask_q  <= mask_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign beat_ready = state_q == COLLECT;
  assign wr_en      = state_q == WRITE;
  assign busy       = state_q != IDLE;
  assign wr_addr    = busy ? waddr_q : '0;
  assign wdata      = buf_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule
